grf_pipe: RTL and testbench
===========================

# grf_pipe

Parametrised general register file for the pipelined datapath. Provides two combinational read ports with write-first bypass from the writeback port, plus a per-register busy scoreboard. The scoreboard is set when an instruction reserves a destination at issue and cleared when that register is written back. It generates the read-after-write and write-after-write stall used by the decode stage and counts committed register writes.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: address width; depth = 2^ADDR_W; register 0 hardwired to zero.
- `PC_W`, default 32: width of the writeback PC tag (trace only).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; clears all registers, busy bits and counter.
- `rd_a1`, `rd_a2`  in  ADDR_W  read addresses.
- `rd_use1`, `rd_use2`  in  1  decode stage actually consumes port 1 / port 2.
- `rd_d1`, `rd_d2`  out  DATA_W  read data, bypassed.
- `rd_busy1`, `rd_busy2`  out  1  source register has an outstanding write not yet available.
- `iss_we`  in  1  issue request reserving destination `iss_a3`.
- `iss_a3`  in  ADDR_W  destination being reserved.
- `wb_we`  in  1  writeback enable.
- `wb_a3`  in  ADDR_W  writeback address.
- `wb_wd`  in  DATA_W  writeback data.
- `wb_pc`  in  PC_W  PC of the writing instruction.
- `stall`  out  1  decode must hold; issue is suppressed internally.
- `wb_cnt`  out  32  committed writes since reset.

## Operation
- Storage: 2^ADDR_W x DATA_W registers, `busy[2^ADDR_W]` bits, 32-bit `wb_cnt`.
- Read port k:
  - `rd_ak` == 0 -> `rd_dk` = 0, `rd_busyk` = 0.
  - Else if `wb_we` and `wb_a3` == `rd_ak` -> `rd_dk` = `wb_wd`, `rd_busyk` = 0 (write-first bypass).
  - Else `rd_dk` = `RF[rd_ak]`, `rd_busyk` = `busy[rd_ak]`.
- `stall` = (`rd_use1` & `rd_busy1`) | (`rd_use2` & `rd_busy2`) | (`iss_we` & `iss_a3` != 0 & `busy[iss_a3]` & !(`wb_we` & `wb_a3` == `iss_a3`)).
- Accepted issue = `iss_we` & !`stall` & `iss_a3` != 0.
  - Sets `busy[iss_a3]` at the next edge.
  - Issue to register 0 is accepted but reserves nothing.
- Writeback with `wb_we` & `wb_a3` != 0:
  - `RF[wb_a3]` <= `wb_wd`, `busy[wb_a3]` <= 0, `wb_cnt` <= `wb_cnt` + 1 (wraps 2^32-1 -> 0).
  - Writing a non-busy register is legal; the data is written and busy stays 0.
- Writeback to register 0 changes no state and does not count.
- Same-cycle accepted issue and writeback to the same register: write happens, busy ends at 1 (the new reservation wins).
- Issue and writeback to different registers are independent.
- Reset has priority over everything: writes, issues and count updates in a reset cycle are discarded.

## Timing
- Reads, bypass, `rd_busy*` and `stall` are combinational; zero latency.
- Register write, busy set/clear and `wb_cnt` update take effect at the posedge and are visible the following cycle.
  - Bypass makes written data visible in the same cycle.
- After reset: all `RF` = 0, all busy = 0, `wb_cnt` = 0. Therefore `rd_d1`/`rd_d2` = 0 (absent bypass), `rd_busy*` = 0, `stall` = 0 unless a WAW/RAW condition is driven in.
- There is no handshake beyond `stall`: the upstream stage must hold its `iss_*`/`rd_*` inputs while `stall` = 1.

## Configuration
- `GRF_TRACE_EN` defined: each posedge with `reset` = 0 and `wb_we` = 1 prints `@<wb_pc hex>: $<wb_a3 decimal> <= <wb_wd hex>` via `$display`, including writes to register 0.
- Not defined: no display statements are compiled; functional behaviour is identical.

## Test plan
- Reset then read all addresses -> every `rd_d` = 0, `rd_busy` = 0, `stall` = 0, `wb_cnt` = 0.
- `wb_we`=1, `wb_a3`=5, `wb_wd`=0x1234ABCD with `rd_a1`=5 in the same cycle -> `rd_d1`=0x1234ABCD combinationally; next cycle `RF[5]` reads the same and `wb_cnt`=1.
- Issue to `iss_a3`=8, then next cycle `rd_a2`=8 with `rd_use2`=1 -> `stall`=1. Writeback to 8 with value 0x55 -> `stall`=0 and `rd_d2`=0x55 in that same cycle.
- Issue to 8 while busy[8]=1 and no writeback -> `stall`=1, busy unchanged. Repeat with writeback to 8 that cycle -> `stall`=0, busy[8]=1 after the edge.
- Writeback to register 0 with 0xFFFFFFFF -> reads of 0 return 0, `wb_cnt` unchanged. With `GRF_TRACE_EN` the line `$ 0 <= ffffffff` is still printed.
- Assert `reset` in the same cycle as issue to 3 and writeback to 3 -> next cycle busy[3]=0, `RF[3]`=0, `wb_cnt`=0.

Source files
------------

// File: rtl/grf_pipe.sv
// grf_pipe: general register file for the pipelined datapath.
// Two combinational read ports with write-first bypass from writeback,
// a per-register busy scoreboard driving the RAW/WAW decode stall, and a
// counter of committed register writes.
// Optional feature: define GRF_TRACE_EN to print one trace line per
// writeback (including writes to register 0); otherwise nothing is printed.
module grf_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_a1,
   input  logic [ADDR_W-1:0] rd_a2,
   input  logic              rd_use1,
   input  logic              rd_use2,
   output logic [DATA_W-1:0] rd_d1,
   output logic [DATA_W-1:0] rd_d2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              iss_we,
   input  logic [ADDR_W-1:0] iss_a3,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_a3,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic [PC_W-1:0]   wb_pc,
   output logic              stall,
   output logic [31:0]       wb_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] rf_r [DEPTH];
   logic [DEPTH-1:0]  busy_r;
   logic [31:0]       wb_cnt_r;

   logic              wb_ok_s;
   logic              iss_ok_s;
   logic              waw_s;
   logic              stall_s;

   // Read port 1: register 0 reads zero, then writeback bypass, then array
   always_comb begin
      rd_d1    = {DATA_W{1'b0}};
      rd_busy1 = 1'b0;
      if (rd_a1 == {ADDR_W{1'b0}}) begin
         rd_d1    = {DATA_W{1'b0}};
         rd_busy1 = 1'b0;
      end else if (wb_we && (wb_a3 == rd_a1)) begin
         rd_d1    = wb_wd;
         rd_busy1 = 1'b0;
      end else begin
         rd_d1    = rf_r[rd_a1];
         rd_busy1 = busy_r[rd_a1];
      end
   end

   // Read port 2: same priority as port 1
   always_comb begin
      rd_d2    = {DATA_W{1'b0}};
      rd_busy2 = 1'b0;
      if (rd_a2 == {ADDR_W{1'b0}}) begin
         rd_d2    = {DATA_W{1'b0}};
         rd_busy2 = 1'b0;
      end else if (wb_we && (wb_a3 == rd_a2)) begin
         rd_d2    = wb_wd;
         rd_busy2 = 1'b0;
      end else begin
         rd_d2    = rf_r[rd_a2];
         rd_busy2 = busy_r[rd_a2];
      end
   end

   // Hazard detection and acceptance of issue / writeback this cycle
   always_comb begin
      wb_ok_s = wb_we && (wb_a3 != {ADDR_W{1'b0}});
      // A reservation of a busy register is fine if that register retires now
      waw_s   = iss_we && (iss_a3 != {ADDR_W{1'b0}}) && busy_r[iss_a3]
                && !(wb_we && (wb_a3 == iss_a3));
      stall_s = (rd_use1 && rd_busy1) || (rd_use2 && rd_busy2) || waw_s;
      iss_ok_s = iss_we && !stall_s && (iss_a3 != {ADDR_W{1'b0}});
   end

   assign stall  = stall_s;
   assign wb_cnt = wb_cnt_r;

   // Register array: cleared on reset, written on a non-zero writeback
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_ok_s) begin
         rf_r[wb_a3] <= wb_wd;
      end else begin
         rf_r[wb_a3] <= rf_r[wb_a3];
      end
   end

   // Busy scoreboard: writeback clears, accepted issue sets (issue wins on same reg)
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= {DEPTH{1'b0}};
      end else begin
         if (wb_ok_s) begin
            busy_r[wb_a3] <= 1'b0;
         end
         if (iss_ok_s) begin
            busy_r[iss_a3] <= 1'b1;
         end
      end
   end

   // Committed-write counter, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cnt_r <= 32'd0;
      end else if (wb_ok_s) begin
         wb_cnt_r <= wb_cnt_r + 32'd1;
      end else begin
         wb_cnt_r <= wb_cnt_r;
      end
   end

`ifdef GRF_TRACE_EN
   // Writeback trace, including writes to register 0
   always_ff @(posedge clk) begin
      if (!reset && wb_we) begin
         $display("@%h: $%d <= %h", wb_pc, wb_a3, wb_wd);
      end
   end
`else
   // The PC tag only feeds the trace
   logic unused_pc_s;
   assign unused_pc_s = ^wb_pc;
`endif

endmodule

// File: tb/tb_grf_pipe.sv
// Scoreboard bench for grf_pipe: stimulus pushes expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_grf_pipe;

   localparam int F_D1 = 0, F_D2 = 1, F_B1 = 2, F_B2 = 3, F_ST = 4, F_CNT = 5;

   typedef struct {
      string       name;
      int          field;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rd_a1, rd_a2, iss_a3, wb_a3;
   logic        rd_use1, rd_use2, iss_we, wb_we;
   logic [31:0] rd_d1, rd_d2, wb_wd, wb_pc, wb_cnt;
   logic        rd_busy1, rd_busy2, stall;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   grf_pipe #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) dut (
      .clk(clk), .reset(reset),
      .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_use1(rd_use1), .rd_use2(rd_use2),
      .rd_d1(rd_d1), .rd_d2(rd_d2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .iss_we(iss_we), .iss_a3(iss_a3),
      .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc),
      .stall(stall), .wb_cnt(wb_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int f);
      case (f)
         F_D1:    return rd_d1;
         F_D2:    return rd_d2;
         F_B1:    return {31'd0, rd_busy1};
         F_B2:    return {31'd0, rd_busy2};
         F_ST:    return {31'd0, stall};
         F_CNT:   return wb_cnt;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare every queued expectation at mid-cycle
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] a;
         e = q.pop_front();
         a = actual(e.field);
         total++;
         if (a !== e.exp) begin
            bad++;
            $display("FAIL %s field=%0d got=%h want=%h", e.name, e.field, a, e.exp);
         end
      end
   end

   task automatic push(input string n, input int f, input logic [31:0] v);
      exp_t e;
      e.name = n; e.field = f; e.exp = v;
      q.push_back(e);
   endtask

   task automatic push_all(input string n, input logic [31:0] d1, input logic [31:0] d2,
                           input logic b1, input logic b2, input logic st, input logic [31:0] c);
      push(n, F_D1, d1);
      push(n, F_D2, d2);
      push(n, F_B1, {31'd0, b1});
      push(n, F_B2, {31'd0, b2});
      push(n, F_ST, {31'd0, st});
      push(n, F_CNT, c);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_a1 = 5'd0; rd_a2 = 5'd0; rd_use1 = 1'b0; rd_use2 = 1'b0;
      iss_we = 1'b0; iss_a3 = 5'd0;
      wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0; wb_pc = 32'h100;
   endtask

   initial begin
      int waited;
      idle();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;

      // Post-reset: all addresses read zero, nothing busy
      for (int a = 0; a < 32; a++) begin
         rd_a1 = a[4:0]; rd_a2 = 5'(31 - a); rd_use1 = 1'b1; rd_use2 = 1'b1;
         push_all("reset_read", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
         cyc();
      end
      idle();

      // Write-first bypass, then committed value and count
      wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'h1234ABCD; rd_a1 = 5'd5;
      push_all("bypass5", 32'h1234ABCD, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(); idle(); rd_a1 = 5'd5;
      push_all("rf5", 32'h1234ABCD, 32'd0, 1'b0, 1'b0, 1'b0, 32'd1);
      cyc(); idle();

      // Reserve 8, then RAW on port 2
      iss_we = 1'b1; iss_a3 = 5'd8;
      push("iss8", F_ST, 32'd0);
      cyc(); idle(); rd_a2 = 5'd8; rd_use2 = 1'b1;
      push("raw8_b2", F_B2, 32'd1);
      push("raw8_st", F_ST, 32'd1);
      cyc(); rd_use2 = 1'b0;
      push("raw8_nouse_b2", F_B2, 32'd1);
      push("raw8_nouse_st", F_ST, 32'd0);
      cyc(); rd_use2 = 1'b1; wb_we = 1'b1; wb_a3 = 5'd8; wb_wd = 32'h55;
      push_all("wb8_bypass", 32'd0, 32'h55, 1'b0, 1'b0, 1'b0, 32'd1);
      cyc(); idle(); rd_a1 = 5'd8;
      push_all("after_wb8", 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 32'd2);
      cyc(); idle();

      // WAW: reserve 8, then try again without / with retiring writeback
      iss_we = 1'b1; iss_a3 = 5'd8;
      cyc(); rd_a1 = 5'd8;
      push("waw_st", F_ST, 32'd1);
      push("waw_b1", F_B1, 32'd1);
      cyc(); idle(); rd_a1 = 5'd8;
      push("waw_hold_b1", F_B1, 32'd1);
      push("waw_hold_st", F_ST, 32'd0);
      cyc();
      iss_we = 1'b1; iss_a3 = 5'd8; wb_we = 1'b1; wb_a3 = 5'd8; wb_wd = 32'h66;
      push("waw_wb_st", F_ST, 32'd0);
      push("waw_wb_d1", F_D1, 32'h66);
      push("waw_wb_b1", F_B1, 32'd0);
      cyc(); idle(); rd_a1 = 5'd8;
      push_all("waw_wb_after", 32'h66, 32'd0, 1'b1, 1'b0, 1'b0, 32'd3);
      cyc();

      // A stalled issue must not reserve its destination
      iss_we = 1'b1; iss_a3 = 5'd10; rd_a1 = 5'd8; rd_use1 = 1'b1;
      push("stall_iss10", F_ST, 32'd1);
      cyc(); idle(); rd_a2 = 5'd10; rd_use2 = 1'b1;
      push("no_res10_b2", F_B2, 32'd0);
      push("no_res10_st", F_ST, 32'd0);
      cyc(); idle();

      // Independent issue (9) and writeback (8) in one cycle
      iss_we = 1'b1; iss_a3 = 5'd9; wb_we = 1'b1; wb_a3 = 5'd8; wb_wd = 32'h77;
      rd_a1 = 5'd8; rd_use1 = 1'b1;
      push("indep_st", F_ST, 32'd0);
      push("indep_d1", F_D1, 32'h77);
      cyc(); idle(); rd_a1 = 5'd8; rd_a2 = 5'd9;
      push_all("indep_after", 32'h77, 32'd0, 1'b0, 1'b1, 1'b0, 32'd4);
      cyc(); idle();

      // Writeback to register 0 changes nothing and does not count
      wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hFFFFFFFF;
      push_all("wb0", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd4);
      cyc(); idle();
      push_all("wb0_after", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd4);
      cyc();

      // Reset wins over same-cycle issue and writeback
      reset = 1'b1; iss_we = 1'b1; iss_a3 = 5'd3; wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'hABC;
      cyc(); idle(); reset = 1'b0; rd_a1 = 5'd3; rd_a2 = 5'd9;
      push_all("post_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(); idle(); rd_a1 = 5'd8; rd_a2 = 5'd5;
      push_all("post_reset_rf", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();

      // Drain the scoreboard with a bounded wait
      waited = 0;
      while (q.size() > 0 && waited < 10) begin
         cyc();
         waited++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
